// File: rtl/console_writer.sv
// Character-stream front end for the tile screen buffer: cursor tracking, control codes, clears.
// Optional build macro CONSOLE_LINE_CLEAR_EN: clear each newly entered row before taking more input.
module console_writer #(
    parameter int H_TILES        = 160,
    parameter int V_TILES        = 60,
    parameter int ADDR_COL_WIDTH = 8,
    parameter int ADDR_ROW_WIDTH = 6,
    parameter int DATA_WIDTH     = 7
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      char_valid_i,
    input  logic [DATA_WIDTH-1:0]     char_i,
    output logic                      char_ready_o,
    output logic                      wr_en_o,
    output logic [ADDR_COL_WIDTH-1:0] col_w_o,
    output logic [ADDR_ROW_WIDTH-1:0] row_w_o,
    output logic [DATA_WIDTH-1:0]     din_o,
    output logic [ADDR_COL_WIDTH-1:0] cursor_col_o,
    output logic [ADDR_ROW_WIDTH-1:0] cursor_row_o
);

    localparam logic [ADDR_COL_WIDTH-1:0] COL_LAST = ADDR_COL_WIDTH'(H_TILES - 1);
    localparam logic [ADDR_ROW_WIDTH-1:0] ROW_LAST = ADDR_ROW_WIDTH'(V_TILES - 1);
    localparam logic [DATA_WIDTH-1:0]     CH_BS    = DATA_WIDTH'(8'h08);
    localparam logic [DATA_WIDTH-1:0]     CH_LF    = DATA_WIDTH'(8'h0A);
    localparam logic [DATA_WIDTH-1:0]     CH_FF    = DATA_WIDTH'(8'h0C);
    localparam logic [DATA_WIDTH-1:0]     CH_CR    = DATA_WIDTH'(8'h0D);
    localparam logic [DATA_WIDTH-1:0]     CH_SPACE = DATA_WIDTH'(8'h20);
    localparam logic [DATA_WIDTH-1:0]     CH_TILDE = DATA_WIDTH'(8'h7E);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CLR_SCREEN = 2'd1
`ifdef CONSOLE_LINE_CLEAR_EN
        , CLR_LINE = 2'd2
`endif
    } state_t;

    state_t                      r_state,   w_state;
    logic [ADDR_COL_WIDTH-1:0]   r_cur_col, w_cur_col;
    logic [ADDR_ROW_WIDTH-1:0]   r_cur_row, w_cur_row;
    logic [ADDR_COL_WIDTH-1:0]   r_clr_col, w_clr_col;
    logic [ADDR_ROW_WIDTH-1:0]   r_clr_row, w_clr_row;
    logic                        r_wr_en,   w_wr_en;
    logic [ADDR_COL_WIDTH-1:0]   r_col_w,   w_col_w;
    logic [ADDR_ROW_WIDTH-1:0]   r_row_w,   w_row_w;
    logic [DATA_WIDTH-1:0]       r_din,     w_din;
    logic                        w_accept;
    logic [ADDR_ROW_WIDTH-1:0]   w_row_adv;

    assign w_accept  = char_valid_i && (r_state == IDLE);
    assign w_row_adv = (r_cur_row == ROW_LAST) ? '0 : r_cur_row + 1'b1;

    always_comb begin
        w_state   = r_state;
        w_cur_col = r_cur_col;
        w_cur_row = r_cur_row;
        w_clr_col = r_clr_col;
        w_clr_row = r_clr_row;
        w_wr_en   = 1'b0;
        w_col_w   = r_col_w;
        w_row_w   = r_row_w;
        w_din     = r_din;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (char_i >= CH_SPACE && char_i <= CH_TILDE) begin
                        w_wr_en = 1'b1;
                        w_col_w = r_cur_col;
                        w_row_w = r_cur_row;
                        w_din   = char_i;
                        if (r_cur_col != COL_LAST) begin
                            w_cur_col = r_cur_col + 1'b1;
                        end else begin
                            w_cur_col = '0;
                            w_cur_row = w_row_adv;
`ifdef CONSOLE_LINE_CLEAR_EN
                            w_state   = CLR_LINE;
                            w_clr_col = '0;
                            w_clr_row = w_row_adv;
`endif
                        end
                    end else if (char_i == CH_CR) begin
                        w_cur_col = '0;
                    end else if (char_i == CH_LF) begin
                        w_cur_col = '0;
                        w_cur_row = w_row_adv;
`ifdef CONSOLE_LINE_CLEAR_EN
                        w_state   = CLR_LINE;
                        w_clr_col = '0;
                        w_clr_row = w_row_adv;
`endif
                    end else if (char_i == CH_BS) begin
                        // Backspace stops at column 0; it never climbs to the previous row.
                        if (r_cur_col != '0) begin
                            w_cur_col = r_cur_col - 1'b1;
                            w_wr_en   = 1'b1;
                            w_col_w   = r_cur_col - 1'b1;
                            w_row_w   = r_cur_row;
                            w_din     = CH_SPACE;
                        end
                    end else if (char_i == CH_FF) begin
                        w_state   = CLR_SCREEN;
                        w_cur_col = '0;
                        w_cur_row = '0;
                        w_clr_col = '0;
                        w_clr_row = '0;
                    end
                end
            end
            CLR_SCREEN: begin
                w_wr_en = 1'b1;
                w_col_w = r_clr_col;
                w_row_w = r_clr_row;
                w_din   = '0;
                if (r_clr_col == COL_LAST) begin
                    w_clr_col = '0;
                    if (r_clr_row == ROW_LAST) begin
                        w_clr_row = '0;
                        w_state   = IDLE;
                    end else begin
                        w_clr_row = r_clr_row + 1'b1;
                    end
                end else begin
                    w_clr_col = r_clr_col + 1'b1;
                end
            end
`ifdef CONSOLE_LINE_CLEAR_EN
            CLR_LINE: begin
                w_wr_en = 1'b1;
                w_col_w = r_clr_col;
                w_row_w = r_clr_row;
                w_din   = '0;
                if (r_clr_col == COL_LAST) begin
                    w_clr_col = '0;
                    w_state   = IDLE;
                end else begin
                    w_clr_col = r_clr_col + 1'b1;
                end
            end
`endif
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state   <= IDLE;
            r_cur_col <= '0;
            r_cur_row <= '0;
            r_clr_col <= '0;
            r_clr_row <= '0;
            r_wr_en   <= 1'b0;
            r_col_w   <= '0;
            r_row_w   <= '0;
            r_din     <= '0;
        end else begin
            r_state   <= w_state;
            r_cur_col <= w_cur_col;
            r_cur_row <= w_cur_row;
            r_clr_col <= w_clr_col;
            r_clr_row <= w_clr_row;
            r_wr_en   <= w_wr_en;
            r_col_w   <= w_col_w;
            r_row_w   <= w_row_w;
            r_din     <= w_din;
        end
    end

    assign char_ready_o = (r_state == IDLE);
    assign wr_en_o      = r_wr_en;
    assign col_w_o      = r_col_w;
    assign row_w_o      = r_row_w;
    assign din_o        = r_din;
    assign cursor_col_o = r_cur_col;
    assign cursor_row_o = r_cur_row;

endmodule

// File: tb/tb_console_writer.sv
// Directed bench for console_writer; adapts its expectations to CONSOLE_LINE_CLEAR_EN.
module tb_console_writer;

    logic       clk_i = 1'b0;
    logic       rstn_i = 1'b1;
    logic       char_valid_i = 1'b0;
    logic [6:0] char_i = 7'h00;
    logic       char_ready_o;
    logic       wr_en_o;
    logic [7:0] col_w_o;
    logic [5:0] row_w_o;
    logic [6:0] din_o;
    logic [7:0] cursor_col_o;
    logic [5:0] cursor_row_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ready_low = 0;
    logic [20:0] wq[$];
    int          wc[$];

    console_writer dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .char_valid_i (char_valid_i),
        .char_i       (char_i),
        .char_ready_o (char_ready_o),
        .wr_en_o      (wr_en_o),
        .col_w_o      (col_w_o),
        .row_w_o      (row_w_o),
        .din_o        (din_o),
        .cursor_col_o (cursor_col_o),
        .cursor_row_o (cursor_row_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [20:0] pack(input int col, input int row, input int d);
        return {8'(col), 6'(row), 7'(d)};
    endfunction

    // Write/ready log sampled on the falling edge, away from the active edge.
    always @(negedge clk_i) begin
        cyc++;
        if (rstn_i) begin
            if (wr_en_o) begin
                wq.push_back({col_w_o, row_w_o, din_o});
                wc.push_back(cyc);
            end
            if (!char_ready_o) ready_low++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        @(posedge clk_i);
        #1;
        wq.delete();
        wc.delete();
        ready_low = 0;
    endtask

    task automatic send(input logic [6:0] c);
        int guard;
        guard = 0;
        @(negedge clk_i);
        char_i = c;
        char_valid_i = 1'b1;
        while (!char_ready_o && guard < 20000) begin
            @(negedge clk_i);
            guard++;
        end
        check("send_ready", {31'd0, char_ready_o}, 32'd1);
        @(posedge clk_i);
        #1;
        char_valid_i = 1'b0;
    endtask

    task automatic settle();
        int guard;
        guard = 0;
        @(negedge clk_i);
        while (!char_ready_o && guard < 20000) begin
            @(negedge clk_i);
            guard++;
        end
        check("settle_ready", {31'd0, char_ready_o}, 32'd1);
        repeat (2) @(negedge clk_i);
    endtask

    task automatic check_cursor(input string tag, input int col, input int row);
        check({tag, "_col"}, 32'(cursor_col_o), 32'(col));
        check({tag, "_row"}, 32'(cursor_row_o), 32'(row));
    endtask

    initial begin
        int errs;
        #3 rstn_i = 1'b0;
        #4;
        check("rst_wr_en", 32'(wr_en_o), 32'd0);
        check("rst_col_w", 32'(col_w_o), 32'd0);
        check("rst_row_w", 32'(row_w_o), 32'd0);
        check("rst_din",   32'(din_o),   32'd0);
        check("rst_ready", 32'(char_ready_o), 32'd1);
        check_cursor("rst_cur", 0, 0);
        @(negedge clk_i);
        rstn_i = 1'b1;

        // "A","B" back to back
        clear_logs();
        send(7'h41);
        send(7'h42);
        settle();
        check("ab_nwr", 32'(wq.size()), 32'd2);
        if (wq.size() == 2) begin
            check("ab_w0", 32'(wq[0]), 32'(pack(0, 0, 8'h41)));
            check("ab_w1", 32'(wq[1]), 32'(pack(1, 0, 8'h42)));
            check("ab_consec", 32'(wc[1] - wc[0]), 32'd1);
        end
        check_cursor("ab_cur", 2, 0);
        check("ab_ready_low", 32'(ready_low), 32'd0);

        // 160 printable characters from column 0
        send(7'h0D);
        clear_logs();
        for (int i = 0; i < 160; i++) send(7'(8'h61 + (i % 26)));
        settle();
        check_cursor("line_cur", 0, 1);
`ifdef CONSOLE_LINE_CLEAR_EN
        check("line_nwr", 32'(wq.size()), 32'd320);
        check("line_ready_low", 32'(ready_low), 32'd160);
        if (wq.size() == 320) begin
            check("line_first", 32'(wq[0]), 32'(pack(0, 0, 8'h61)));
            check("line_last", 32'(wq[159]), 32'(pack(159, 0, 8'h64)));
            check("line_clr_gap", 32'(wc[160] - wc[159]), 32'd1);
            errs = 0;
            for (int k = 0; k < 160; k++) if (wq[160 + k] !== pack(k, 1, 0)) errs++;
            check("line_clr_seq", 32'(errs), 32'd0);
        end
`else
        check("line_nwr", 32'(wq.size()), 32'd160);
        check("line_ready_low", 32'(ready_low), 32'd0);
        if (wq.size() == 160) begin
            check("line_first", 32'(wq[0]), 32'(pack(0, 0, 8'h61)));
            check("line_last", 32'(wq[159]), 32'(pack(159, 0, 8'h64)));
        end
`endif

        // LF on the last row wraps to row 0
        for (int i = 0; i < 58; i++) send(7'h0A);
        settle();
        check_cursor("row59_cur", 0, 59);
        clear_logs();
        send(7'h0A);
        settle();
        check_cursor("lfwrap_cur", 0, 0);
`ifdef CONSOLE_LINE_CLEAR_EN
        check("lfwrap_nwr", 32'(wq.size()), 32'd160);
        check("lfwrap_ready_low", 32'(ready_low), 32'd160);
        if (wq.size() == 160) begin
            check("lfwrap_w0", 32'(wq[0]), 32'(pack(0, 0, 0)));
            check("lfwrap_w159", 32'(wq[159]), 32'(pack(159, 0, 0)));
        end
`else
        check("lfwrap_nwr", 32'(wq.size()), 32'd0);
        check("lfwrap_ready_low", 32'(ready_low), 32'd0);
`endif

        // Backspace handling from (5,3)
        for (int i = 0; i < 3; i++) send(7'h0A);
        for (int i = 0; i < 5; i++) send(7'h78);
        settle();
        check_cursor("bs_start", 5, 3);
        clear_logs();
        send(7'h08);
        send(7'h08);
        send(7'h0D);
        settle();
        check("bs_nwr", 32'(wq.size()), 32'd2);
        if (wq.size() == 2) begin
            check("bs_w0", 32'(wq[0]), 32'(pack(4, 3, 8'h20)));
            check("bs_w1", 32'(wq[1]), 32'(pack(3, 3, 8'h20)));
        end
        check_cursor("bs_cur", 0, 3);
        clear_logs();
        send(7'h08);
        settle();
        check("bs0_nwr", 32'(wq.size()), 32'd0);
        check_cursor("bs0_cur", 0, 3);

        // Form feed clears the whole screen
        clear_logs();
        send(7'h0C);
        settle();
        check("ff_nwr", 32'(wq.size()), 32'd9600);
        check("ff_ready_low", 32'(ready_low), 32'd9600);
        if (wq.size() == 9600) begin
            errs = 0;
            for (int k = 0; k < 9600; k++) if (wq[k] !== pack(k % 160, k / 160, 0)) errs++;
            check("ff_order", 32'(errs), 32'd0);
            check("ff_consec", 32'(wc[9599] - wc[0]), 32'd9599);
        end
        check_cursor("ff_cur", 0, 0);
        clear_logs();
        send(7'h51);
        send(7'h07);
        send(7'h7F);
        settle();
        check("ign_nwr", 32'(wq.size()), 32'd1);
        check_cursor("ign_cur", 1, 0);

        // Reset in the middle of a screen clear
        send(7'h0C);
        repeat (1000) @(negedge clk_i);
        check("midff_busy", 32'(wr_en_o), 32'd1);
        #2 rstn_i = 1'b0;
        #1;
        check("midff_wr_en", 32'(wr_en_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        #1;
        check("midff_ready", 32'(char_ready_o), 32'd1);
        check_cursor("midff_cur", 0, 0);
        clear_logs();
        send(7'h5A);
        settle();
        check("midff_nwr", 32'(wq.size()), 32'd1);
        if (wq.size() == 1) check("midff_w0", 32'(wq[0]), 32'(pack(0, 0, 8'h5A)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
